dtw_result_serializer: RTL

- Collects match results (minval, position, qid) from NUM_CORES parallel DTW cores.
- Arbitrates between cores round-robin and serialises each result as one fixed-length record on a single AXI-Stream master.
- Sits between the DTW core array and the M00_AXIS output path.
- Successor to the single-core sink path: adds multi-core arbitration, record framing with TLAST, and backpressure handling.

---
 rtl/dtw_result_serializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dtw_result_serializer.sv
// Round-robin collector of DTW core results, emitting one fixed-length AXI-Stream record per result.
// Optional macro DTW_SER_SEQ_EN appends a 32-bit sequence-number beat (carrying TLAST) to each record.
module dtw_result_serializer #(
    parameter int NUM_CORES            = 4,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int QID_WIDTH            = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic [NUM_CORES-1:0]              res_valid,
    output logic [NUM_CORES-1:0]              res_ready,
    input  logic [NUM_CORES*32-1:0]           res_minval,
    input  logic [NUM_CORES*32-1:0]           res_position,
    input  logic [NUM_CORES*QID_WIDTH-1:0]    res_qid,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              busy,
    output logic [15:0]                       records_sent
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        MINV = 3'd2,
        POS  = 3'd3
`ifdef DTW_SER_SEQ_EN
        ,
        SEQ  = 3'd4
`endif
    } state_t;

    state_t      state;
    logic [3:0]  ptr;
    logic [31:0] cap_minval;
    logic [31:0] cap_position;

    logic        grant_found;
    logic [3:0]  grant_idx;
    logic [31:0] sel_minval;
    logic [31:0] sel_position;
    logic [15:0] sel_qid;

`ifdef DTW_SER_SEQ_EN
    logic [31:0] seq_cnt;
`endif

    // Search starts just past the last granted core so every waiting core gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 4'd0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            for (int j = 0; j < NUM_CORES; j++) begin
                if (!grant_found && res_valid[j] &&
                    (j == ((int'(ptr) + off) % NUM_CORES))) begin
                    grant_found = 1'b1;
                    grant_idx   = 4'(j);
                end
            end
        end
    end

    always_comb begin
        sel_minval   = '0;
        sel_position = '0;
        sel_qid      = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (grant_idx == 4'(j)) begin
                sel_minval                = res_minval[32*j +: 32];
                sel_position              = res_position[32*j +: 32];
                sel_qid[QID_WIDTH-1:0]    = res_qid[QID_WIDTH*j +: QID_WIDTH];
            end
        end
    end

    always_comb begin
        res_ready = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            res_ready[j] = (state == IDLE) && grant_found && (grant_idx == 4'(j));
        end
    end

    assign M_AXIS_TSTRB = '1;
    assign busy         = (state != IDLE);

    // TVALID is high in every beat state, so a beat completes whenever TREADY is seen.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state         <= IDLE;
            ptr           <= 4'(NUM_CORES - 1);
            cap_minval    <= '0;
            cap_position  <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            records_sent  <= '0;
`ifdef DTW_SER_SEQ_EN
            seq_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cap_minval    <= sel_minval;
                        cap_position  <= sel_position;
                        ptr           <= grant_idx;
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= {4'b0000, grant_idx, 8'h00, sel_qid};
                        M_AXIS_TLAST  <= 1'b0;
                        state         <= HDR;
                    end
                end
                HDR: begin
                    if (M_AXIS_TREADY) begin
                        M_AXIS_TDATA <= cap_minval;
                        state        <= MINV;
                    end
                end
                MINV: begin
                    if (M_AXIS_TREADY) begin
                        M_AXIS_TDATA <= cap_position;
`ifdef DTW_SER_SEQ_EN
                        M_AXIS_TLAST <= 1'b0;
`else
                        M_AXIS_TLAST <= 1'b1;
`endif
                        state        <= POS;
                    end
                end
                POS: begin
                    if (M_AXIS_TREADY) begin
`ifdef DTW_SER_SEQ_EN
                        M_AXIS_TDATA  <= seq_cnt;
                        M_AXIS_TLAST  <= 1'b1;
                        state         <= SEQ;
`else
                        M_AXIS_TVALID <= 1'b0;
                        M_AXIS_TLAST  <= 1'b0;
                        M_AXIS_TDATA  <= '0;
                        records_sent  <= records_sent + 16'd1;
                        state         <= IDLE;
`endif
                    end
                end
`ifdef DTW_SER_SEQ_EN
                SEQ: begin
                    if (M_AXIS_TREADY) begin
                        M_AXIS_TVALID <= 1'b0;
                        M_AXIS_TLAST  <= 1'b0;
                        M_AXIS_TDATA  <= '0;
                        seq_cnt       <= seq_cnt + 32'd1;
                        records_sent  <= records_sent + 16'd1;
                        state         <= IDLE;
                    end
                end
`endif
                default: begin
                    M_AXIS_TVALID <= 1'b0;
                    M_AXIS_TLAST  <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
